// File: rtl/tw_pkg.sv
// Shared types and helpers for the threewire arbiter and its round-robin selector.
// No logic; state encoding, default widths and a width helper only.
package tw_pkg;

  localparam int DEF_ADDR_BITS = 9;
  localparam int DEF_DATA_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_COMPLETE  = 3'd4
  } tw_state_e;

  // Never returns 0 so a single-entry range still gets a 1-bit index.
  function automatic int tw_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/tw_rr_select.sv
// Round-robin priority pick: first set bit of eligible at or above ptr, with wrap.
// Purely combinational, zero latency; no backpressure (caller decides when to use the pick).
module tw_rr_select #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!grant_vld && eligible[(int'(ptr) + i) % N]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/tw_arbiter.sv
// Shares one threewire master between NUM_REQ requesters, round-robin, one transaction at a time.
// Grant to out_tw_start is 1 cycle; requesters hold in_req until their one-cycle out_ack.
module tw_arbiter
  import tw_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int ADDR_BITS     = DEF_ADDR_BITS,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int START_TIMEOUT = 255
) (
  input  logic                           in_clk,
  input  logic                           in_rst,
  input  logic [NUM_REQ-1:0]             in_req,
  input  logic [NUM_REQ-1:0]             in_mode_wr,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   in_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   in_wr_data,
  output logic [NUM_REQ-1:0]             out_ack,
  output logic                           out_err,
  output logic [DATA_BITS-1:0]           out_rd_data,
  output logic                           out_busy,
  output logic                           out_tw_start,
  output logic                           out_tw_mode_wr,
  output logic [ADDR_BITS-1:0]           out_tw_addr,
  output logic [DATA_BITS-1:0]           out_tw_wr_data,
  input  logic [DATA_BITS-1:0]           in_tw_rd_data,
  input  logic                           in_tw_running
);

  localparam int IDX_W = tw_clog2(NUM_REQ);
  localparam int CNT_W = tw_clog2(START_TIMEOUT + 1);

  tw_state_e            state_q, state_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   holdoff_q, holdoff_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 tw_mode_wr_q, tw_mode_wr_d;
  logic [ADDR_BITS-1:0] tw_addr_q, tw_addr_d;
  logic [DATA_BITS-1:0] tw_wr_data_q, tw_wr_data_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;

  logic [NUM_REQ-1:0]   eligible;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_vld;

  // A timed-out threewire may still be running; hold off new grants until it goes idle.
  assign eligible = (state_q == ST_IDLE && !in_tw_running) ? (in_req & ~holdoff_q) : '0;

  tw_rr_select #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .grant_idx (sel_idx),
    .grant_vld (sel_vld)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    holdoff_d    = holdoff_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    tw_mode_wr_d = tw_mode_wr_q;
    tw_addr_d    = tw_addr_q;
    tw_wr_data_d = tw_wr_data_q;
    rd_data_d    = rd_data_q;

    case (state_q)
      ST_IDLE: begin
        holdoff_d = '0;
        if (sel_vld) begin
          grant_d      = sel_idx;
          tw_mode_wr_d = in_mode_wr[sel_idx];
          tw_addr_d    = in_addr[int'(sel_idx) * ADDR_BITS +: ADDR_BITS];
          tw_wr_data_d = in_wr_data[int'(sel_idx) * DATA_BITS +: DATA_BITS];
          state_d      = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (in_tw_running) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = ST_COMPLETE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!in_tw_running) begin
          if (!tw_mode_wr_q) rd_data_d = in_tw_rd_data;
          state_d = ST_COMPLETE;
        end
      end
      ST_COMPLETE: begin
        holdoff_d = NUM_REQ'(1) << grant_q;
        ptr_d     = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        err_d     = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      ptr_q        <= '0;
      holdoff_q    <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      tw_mode_wr_q <= 1'b0;
      tw_addr_q    <= '0;
      tw_wr_data_q <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      holdoff_q    <= holdoff_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      tw_mode_wr_q <= tw_mode_wr_d;
      tw_addr_q    <= tw_addr_d;
      tw_wr_data_q <= tw_wr_data_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign out_busy       = (state_q != ST_IDLE);
  assign out_tw_start   = (state_q == ST_START);
  assign out_ack        = (state_q == ST_COMPLETE) ? (NUM_REQ'(1) << grant_q) : '0;
  assign out_err        = (state_q == ST_COMPLETE) && err_q;
  assign out_rd_data    = rd_data_q;
  assign out_tw_mode_wr = tw_mode_wr_q;
  assign out_tw_addr    = tw_addr_q;
  assign out_tw_wr_data = tw_wr_data_q;

endmodule

// File: doc/tw_arbiter.md
Name: tw_arbiter

Overview:
- Shares one threewire master between NUM_REQ independent requesters, e.g. the host protocol decoder and an on-chip register poller.
- Selects requests round-robin and sequences one threewire transaction: start, wait for busy, wait for completion.
- Returns read data and a one-cycle completion ack to the granted requester.
- Sits between the requesters and the threewire instance; it owns that instance's start/mode/addr/wr_data inputs.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_BITS, 9, threewire address width
DATA_BITS, 16, threewire data width
START_TIMEOUT, 255, max cycles from start pulse to in_tw_running=1 before abort

Ports:
in_clk  input  1  clock
in_rst  input  1  asynchronous, active-high reset
in_req  input  NUM_REQ  per-requester request level
in_mode_wr  input  NUM_REQ  per-requester 1=write, 0=read
in_addr  input  NUM_REQ*ADDR_BITS  packed addresses, requester i at [i*ADDR_BITS +: ADDR_BITS]
in_wr_data  input  NUM_REQ*DATA_BITS  packed write data, same packing
out_ack  output  NUM_REQ  one-cycle completion pulse, one-hot
out_err  output  1  high with out_ack when transaction aborted on timeout
out_rd_data  output  DATA_BITS  read result of last completed transaction
out_busy  output  1  high whenever state != IDLE
out_tw_start  output  1  one-cycle start to threewire
out_tw_mode_wr  output  1  mode to threewire
out_tw_addr  output  ADDR_BITS  address to threewire
out_tw_wr_data  output  DATA_BITS  write data to threewire
in_tw_rd_data  input  DATA_BITS  threewire read data
in_tw_running  input  1  threewire in-progress flag

Behaviour:
- Reset (in_rst, asynchronous): state IDLE; all outputs 0; rr pointer 0; holdoff mask 0; timeout counter 0.
- Requester rule: hold in_req=1 with mode/addr/data stable until out_ack; in_req must be low in the cycle after out_ack. Dropping in_req before ack does not cancel a granted transaction.
- States:
  - IDLE: eligible = in_req & ~holdoff. If eligible != 0, latch grant index, mode/addr/wr_data into out_tw_*, then go to START. Holdoff clears every IDLE cycle.
  - START: out_tw_start=1 for exactly this cycle; clear timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY: if in_tw_running=1, go to WAIT_DONE. Else if counter == START_TIMEOUT, set err flag and go to COMPLETE. Else increment counter.
  - WAIT_DONE: when in_tw_running=0, latch out_rd_data <= in_tw_rd_data on reads only (writes leave it unchanged), then go to COMPLETE. No timeout in this state.
  - COMPLETE: out_ack[grant]=1 and out_err=err for this cycle only; set holdoff bit for grant; rr pointer <= grant+1, wrapping at NUM_REQ-1 to 0; clear err; go to IDLE.
- Arbitration: first eligible index searched from the rr pointer upward, with wrap-around. Served requester gets lowest priority next round.
- Simultaneous requests: all other inputs are ignored while not in IDLE.
- Latency: in_req seen at edge k -> START during cycle k+1 -> out_tw_start high in cycle k+1. Minimum request-to-ack is 4 cycles plus threewire duration.
- out_tw_* stay stable from START through COMPLETE and hold their values in IDLE.
- Timeout path: the threewire block may still be active afterwards. The arbiter still waits for in_tw_running=0 in IDLE before granting again: eligible is forced to 0 while in_tw_running=1.

Decomposition:
- Package tw_pkg holds: state encoding localparams (IDLE, START, WAIT_BUSY, WAIT_DONE, COMPLETE), default ADDR_BITS/DATA_BITS, and a clog2 function for the grant index width.
- Sub-module tw_rr_select: purely combinational round-robin priority selector (eligible vector + pointer -> grant index + valid), reusable by other shared-resource controllers.

Test Plan:
- Single read, req0 addr 0x1A5, threewire model returns 0xBEEF after 40 cycles -> one out_tw_start pulse with addr 0x1A5, mode 0; out_ack=2'b01 once; out_rd_data=0xBEEF; out_err=0.
- Simultaneous req0 write (addr 0x003, data 0x1234) and req1 read (addr 0x010) from reset -> req0 served first, then req1. Exactly two start pulses, with 0x003/0x1234/mode1 then 0x010/mode0.
- req0 and req1 held continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; no requester served twice in a row.
- Model never raises in_tw_running -> out_ack with out_err=1 exactly 257 cycles after the start pulse, with START_TIMEOUT=255. Next grant occurs only after the model is idle.
- Write completes after a prior read of 0x5A5A -> out_rd_data stays 0x5A5A.
- in_rst asserted during WAIT_DONE -> all outputs 0 immediately; after release, a pending req1 is granted with pointer back at 0.
